// File: rtl/inst_cache_pkg.sv
// Shared constants, FSM state type and saturating-counter helper for the
// direct-mapped instruction cache.
package inst_cache_pkg;
  localparam int WORD_SIZE = 16;
  localparam int LINE_W    = 64;
  localparam int ADDR_W    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/cache_array.sv
// Tag, valid and line storage for the instruction cache: one write port,
// combinational read. Only the valid bits are reset.
module cache_array
  import inst_cache_pkg::*;
#(
  parameter int LINES = 4,
  parameter int IDX_W = 2,
  parameter int TAG_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [LINE_W-1:0] wline_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic              rvalid_o,
  output logic [TAG_W-1:0]  rtag_o,
  output logic [LINE_W-1:0] rline_o
);
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] line_q [LINES];

  // A clear coinciding with a write wins: data lands but the line stays invalid.
  always_comb begin
    valid_d = valid_q;
    if (we_i) valid_d[widx_i] = 1'b1;
    if (clear_i) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      line_q[widx_i] <= wline_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rline_o  = line_q[ridx_i];
endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between the CPU fetch port and instruction
// memory: same-cycle hits, IDLE/FILL line-refill FSM, saturating hit/miss counters.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINES = 4,
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_m1,
  input  logic [15:0]       address1,
  output logic [15:0]       data1,
  output logic              i_ready,
  input  logic              invalidate,
  output logic              mem_read,
  output logic [15:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  logic [OFF_W-1:0]     off;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic                 rvalid;
  logic [TAG_W-1:0]     rtag;
  logic [LINE_W-1:0]    rline;
  logic [WORD_SIZE-1:0] word;
  logic                 hit;
  logic                 miss_start;
  logic                 fill_we;

  state_t      state_q;
  logic        mem_read_q;
  logic [15:0] mem_addr_q;
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  assign off = address1[OFF_W-1:0];
  assign idx = address1[OFF_W +: IDX_W];
  assign tag = address1[ADDR_W-1 -: TAG_W];

  // The latched fill address in mem_addr_q also supplies the write index and tag.
  assign fill_we = (state_q == FILL) && mem_ack && !reset;

  cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (invalidate),
    .we_i     (fill_we),
    .widx_i   (mem_addr_q[OFF_W +: IDX_W]),
    .wtag_i   (mem_addr_q[ADDR_W-1 -: TAG_W]),
    .wline_i  (mem_rdata),
    .ridx_i   (idx),
    .rvalid_o (rvalid),
    .rtag_o   (rtag),
    .rline_o  (rline)
  );

  always_comb begin
    word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (off == w[OFF_W-1:0]) word = rline[w*WORD_SIZE +: WORD_SIZE];
    end
  end

  assign hit        = !reset && (state_q == IDLE) && read_m1 && rvalid && (rtag == tag);
  assign miss_start = !reset && (state_q == IDLE) && read_m1 && !hit;

  assign i_ready = read_m1 ? hit : 1'b1;
  assign data1   = hit ? word : '0;

  assign hit_count_d  = hit        ? sat_inc(hit_count_q)  : hit_count_q;
  assign miss_count_d = miss_start ? sat_inc(miss_count_q) : miss_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            state_q    <= FILL;
            mem_read_q <= 1'b1;
            mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        FILL: begin
          if (mem_ack) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Keep the memory port quiet for the whole reset cycle, not just after it.
  assign mem_read   = mem_read_q && !reset;
  assign mem_addr   = reset ? '0 : mem_addr_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter LINES, default 4, number of direct-mapped lines (power of two).
REQ-002 Parameter WORDS, default 4, 16-bit words per line; fixed at 4 in this revision.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 read_m1  input  1  CPU instruction-fetch request.
REQ-006 address1  input  16  CPU fetch word address.
REQ-007 data1  output  16  fetched instruction word; valid when i_ready=1.
REQ-008 i_ready  output  1  hit indication; CPU stalls fetch while read_m1=1 and i_ready=0.
REQ-009 invalidate  input  1  clears all valid bits.
REQ-010 mem_read  output  1  line-fill request to instruction memory.
REQ-011 mem_addr  output  16  line-aligned fill address; bits [1:0]=0.
REQ-012 mem_ack  input  1  one-cycle pulse; mem_rdata valid in the same cycle.
REQ-013 mem_rdata  input  64  fill line; word n at bits [16n+15:16n].
REQ-014 hit_count  output  16  saturating count of hits.
REQ-015 miss_count  output  16  saturating count of misses.

Function
REQ-016 Address split SHALL be: offset=address1[1:0], index=address1[log2(LINES)+1:2], tag=remaining upper bits.
REQ-017 Hit SHALL mean state IDLE, read_m1=1, valid[index]=1 and tag match; it is combinational in the same cycle.
REQ-018 On a hit, i_ready SHALL be 1 and data1 SHALL be the addressed word, with zero added latency.
REQ-019 i_ready SHALL be 0 whenever read_m1=1 and no hit; i_ready SHALL be 1 when read_m1=0.
REQ-020 data1 SHALL be 16'h0000 when i_ready=0 or read_m1=0.
REQ-021 FSM states SHALL be IDLE and FILL only.
REQ-022 IDLE->FILL SHALL occur on read_m1=1 with a miss; tag and index are latched at that edge.
REQ-023 In FILL, mem_read SHALL be 1 and mem_addr SHALL be {latched tag, latched index, 2'b00}; both SHALL be 0 in IDLE.
REQ-024 FILL->IDLE SHALL occur on the edge sampling mem_ack=1; the line, tag and valid are written at that edge.
REQ-025 Miss penalty SHALL be: miss seen in cycle 0, mem_read=1 from cycle 1, ack in cycle k, hit (i_ready=1) in cycle k+1.
REQ-026 address1 changes during FILL SHALL NOT affect the fill in progress; the new address is looked up in IDLE afterwards.
REQ-027 mem_ack in IDLE SHALL be ignored.
REQ-028 invalidate SHALL clear all valid bits at the next edge in any state; if coincident with the fill-completing mem_ack, the data is written but valid stays 0.
REQ-029 hit_count SHALL increment on each edge sampling a hit; miss_count SHALL increment on each IDLE->FILL transition; both hold at 16'hFFFF.

Reset
REQ-030 reset=1 at an edge SHALL force state IDLE, clear all valid bits, and zero hit_count and miss_count.
REQ-031 While in reset, and in the first cycle after it, mem_read SHALL be 0, mem_addr SHALL be 0 and data1 SHALL be 0.
REQ-032 Reset during FILL SHALL abandon the fill; a later mem_ack for it SHALL be ignored per REQ-027.
REQ-033 Data and tag arrays SHALL NOT require reset.

Structure
REQ-034 A shared package SHALL hold WORD_SIZE=16, the line-width constant (64), and the FSM state enum {IDLE, FILL}.
REQ-035 One sub-module, cache_array (tag, valid and data storage with write port and combinational read), SHALL be used.
REQ-036 The FSM and counters SHALL live in inst_cache; the block is instantiated between the CPU fetch port and instruction memory.

Verification
REQ-037 Cold read of 16'h0014, memory acks after 3 cycles with line 64'h0004_0003_0002_0001 -> mem_addr=16'h0014, miss_count=1; next cycle data1=16'h0001, i_ready=1.
REQ-038 After REQ-037, read 16'h0017 -> same-cycle hit, data1=16'h0004, hit_count=2, mem_read stays 0.
REQ-039 Read 16'h0114 (same index 1, different tag) -> miss, refill, line replaced; re-read 16'h0014 -> miss again.
REQ-040 Assert reset in the 2nd cycle of a FILL, then pulse mem_ack -> state IDLE, no valid line, counters 0, ack ignored.
REQ-041 Pulse invalidate in the same cycle as the fill mem_ack -> the next read of that address misses again.
REQ-042 Force hit_count to 16'hFFFE, then issue 3 hits -> hit_count=16'hFFFF.
